// File: rtl/gray_run_ctrl_pkg.sv
// rtl/gray_run_ctrl_pkg.sv - shared state encoding and default widths for the gray counter sequencer
package gray_run_ctrl_pkg;

  localparam int DEF_CNT_W  = 3;
  localparam int DEF_STEP_W = 8;
  localparam int DEF_WRAP_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CLR  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/gray_run_ctrl_checker.sv
// rtl/gray_run_ctrl_checker.sv - flags any observed counter step that is not a legal gray transition
module gray_run_ctrl_checker
  import gray_run_ctrl_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] gray_in,
  input  logic             en,
  input  logic             restart,
  input  logic             clear,
  output logic             err
);

  logic [CNT_W-1:0] gray_d;
  logic             en_d;
  logic             chk_vld;
  logic [CNT_W-1:0] diff;
  logic             one_flip;
  logic             step_ok;

  // An enabled step must flip exactly one bit; an idle cycle must flip none.
  assign diff     = gray_in ^ gray_d;
  assign one_flip = (diff != '0) && ((diff & (diff - 1'b1)) == '0);
  assign step_ok  = en_d ? one_flip : (diff == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      gray_d  <= '0;
      en_d    <= 1'b0;
      chk_vld <= 1'b0;
      err     <= 1'b0;
    end else begin
      gray_d  <= gray_in;
      en_d    <= en;
      chk_vld <= ~restart;
      if (clear)
        err <= 1'b0;
      else if (chk_vld && !step_ok)
        err <= 1'b1;
    end
  end

endmodule

// File: rtl/gray_run_ctrl.sv
// rtl/gray_run_ctrl.sv - runs N enabled steps of a gray counter with optional clear, overflow stop and pause
module gray_run_ctrl
  import gray_run_ctrl_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int STEP_W = DEF_STEP_W,
  parameter int WRAP_W = DEF_WRAP_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Cmd_valid,
  output logic              Cmd_ready,
  input  logic [STEP_W-1:0] Cmd_steps,
  input  logic              Cmd_clear,
  input  logic              Cmd_stop_ovf,
  input  logic              Pause,
  input  logic              Abort,
  input  logic [CNT_W-1:0]  Gray_in,
  input  logic              Ovf_in,
  output logic              En,
  output logic              Cnt_clr,
  output logic              Busy,
  output logic              Done,
  output logic [STEP_W-1:0] Steps_left,
  output logic              Ovf_seen,
  output logic [WRAP_W-1:0] Wrap_cnt,
  output logic              Err
);

  state_t state, state_nxt;
  logic   stop_ovf_l;
  logic   ovf_d;
  logic   ovf_evt;
  logic   accept;

  assign ovf_evt = Ovf_in & ~ovf_d;
  assign accept  = (state == ST_IDLE) & Cmd_valid & Cmd_ready;

  always_ff @(posedge Clk) begin
    if (Reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (Abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (Cmd_clear)
              state_nxt = ST_CLR;
            else if (Cmd_steps == '0)
              state_nxt = ST_DONE;
            else
              state_nxt = ST_RUN;
          end
        end
        ST_CLR:  state_nxt = (Steps_left == '0) ? ST_DONE : ST_RUN;
        ST_RUN: begin
          if (stop_ovf_l && ovf_evt)
            state_nxt = ST_DONE;
          else if (En && (Steps_left == {{(STEP_W-1){1'b0}}, 1'b1}))
            state_nxt = ST_DONE;
        end
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Abort masks every strobe in the cycle it is seen.
  always_comb begin
    Cmd_ready = (state == ST_IDLE) & ~Abort;
    En        = (state == ST_RUN) & ~Pause & ~(stop_ovf_l & ovf_evt) & ~Abort;
    Cnt_clr   = (state == ST_CLR) & ~Abort;
    Done      = (state == ST_DONE) & ~Abort;
    Busy      = (state != ST_IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Steps_left <= '0;
      stop_ovf_l <= 1'b0;
      ovf_d      <= 1'b0;
      Ovf_seen   <= 1'b0;
      Wrap_cnt   <= '0;
    end else begin
      ovf_d <= Ovf_in;
      if (Abort) begin
        Steps_left <= '0;
      end else if (accept) begin
        Steps_left <= Cmd_steps;
        stop_ovf_l <= Cmd_stop_ovf;
        Ovf_seen   <= 1'b0;
        Wrap_cnt   <= '0;
      end else begin
        if (En)
          Steps_left <= Steps_left - 1'b1;
        if ((state != ST_IDLE) && ovf_evt) begin
          Ovf_seen <= 1'b1;
          if (Wrap_cnt != '1)
            Wrap_cnt <= Wrap_cnt + 1'b1;
        end
      end
    end
  end

  gray_run_ctrl_checker #(
    .CNT_W(CNT_W)
  ) u_checker (
    .clk     (Clk),
    .reset   (Reset),
    .gray_in (Gray_in),
    .en      (En),
    .restart (accept | Cnt_clr),
    .clear   (accept),
    .err     (Err)
  );

endmodule
